// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird matrix: game states, frame period
// and matrix geometry used by the bird cells, pipe shifter and game controller.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        CRASH,
        OVER
    } game_state_t;

    localparam int unsigned TICK_PERIOD_DEFAULT = 1792;
    localparam int unsigned MATRIX_W            = 8;

endpackage

// File: rtl/frame_tick.sv
// Modulo-PERIOD free-running counter with synchronous clear; tick is high for
// the one cycle the counter sits at PERIOD-1, and the counter wraps on that cycle.
module frame_tick
    import flappy_pkg::*;
#(
    parameter int unsigned PERIOD = TICK_PERIOD_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(PERIOD - 1));

    always_ff @(posedge clock) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/bird_collision_ctrl.sv
// Game-state and collision controller: detects bird/pipe or ground hits, holds
// lossDetect for FLASH_TICKS frames, sequences start/over and keeps the score.
module bird_collision_ctrl
    import flappy_pkg::*;
#(
    parameter int unsigned TICK_PERIOD = TICK_PERIOD_DEFAULT,
    parameter int unsigned FLASH_TICKS = 6,
    parameter int unsigned SCORE_MAX   = 99
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                KEY0,
    input  logic                groundOut,
    input  logic [MATRIX_W-1:0] birdCol,
    input  logic [MATRIX_W-1:0] pipeCol,
    input  logic                pipePass,
    output logic                lossDetect,
    output logic                playing,
    output logic                gameOver,
    output logic [6:0]          score
);

    localparam int unsigned FW = $clog2(FLASH_TICKS + 1);

    game_state_t   state, state_next;
    logic          key_prev;
    logic          press;
    logic          collision;
    logic          tick;
    logic          frame_clear;
    logic [FW-1:0] flash;
    logic          loss_d, playing_d, over_d;

    assign press       = key_prev & ~KEY0;
    assign collision   = groundOut | (|(birdCol & pipeCol));
    assign frame_clear = (state == IDLE) && press;

    frame_tick #(
        .PERIOD(TICK_PERIOD)
    ) u_frame_tick (
        .clock(clock),
        .reset(reset),
        .clear(frame_clear),
        .tick (tick)
    );

    // State and outputs share one register stage so outputs follow state_next
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lossDetect <= 1'b0;
            playing    <= 1'b0;
            gameOver   <= 1'b0;
        end else begin
            state      <= state_next;
            lossDetect <= loss_d;
            playing    <= playing_d;
            gameOver   <= over_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press) state_next = PLAY;
            PLAY:    if (collision) state_next = CRASH;
            CRASH:   if (tick && flash == FW'(1)) state_next = OVER;
            OVER:    if (press) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        loss_d    = (state_next == CRASH);
        playing_d = (state_next == PLAY);
        over_d    = (state_next == OVER);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_prev <= 1'b1;
            flash    <= '0;
            score    <= '0;
        end else begin
            key_prev <= KEY0;

            if (state == PLAY && collision) begin
                flash <= FW'(FLASH_TICKS);
            end else if (state == CRASH && tick) begin
                flash <= flash - FW'(1);
            end

            // Score reads 0 throughout IDLE, including the edge leaving OVER
            if (state == IDLE || (state == OVER && press)) begin
                score <= '0;
            end else if (state == PLAY && pipePass && !collision &&
                         score < 7'(SCORE_MAX)) begin
                score <= score + 7'(1);
            end
        end
    end

endmodule

// File: tb/tb_bird_collision_ctrl.sv
// Directed bench for bird_collision_ctrl using a 16-clock frame so crash
// sequences complete quickly; expected values are worked out by hand.
module tb_bird_collision_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       KEY0;
    logic       groundOut;
    logic [7:0] birdCol;
    logic [7:0] pipeCol;
    logic       pipePass;
    logic       lossDetect;
    logic       playing;
    logic       gameOver;
    logic [6:0] score;

    int unsigned total = 0;
    int unsigned bad   = 0;

    bird_collision_ctrl #(
        .TICK_PERIOD(16),
        .FLASH_TICKS(6),
        .SCORE_MAX  (99)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .KEY0      (KEY0),
        .groundOut (groundOut),
        .birdCol   (birdCol),
        .pipeCol   (pipeCol),
        .pipePass  (pipePass),
        .lossDetect(lossDetect),
        .playing   (playing),
        .gameOver  (gameOver),
        .score     (score)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press_key();
        KEY0 = 1'b0;
        step();
        KEY0 = 1'b1;
    endtask

    task automatic pulse_pass();
        pipePass = 1'b1;
        step();
        pipePass = 1'b0;
        step();
    endtask

    task automatic wait_over(output int n);
        n = 0;
        while (!gameOver && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int rises;
        logic prev;

        reset = 1'b1; KEY0 = 1'b1; groundOut = 1'b0; pipePass = 1'b0;
        birdCol = '0; pipeCol = '0;
        step(); step();
        reset = 1'b0;
        check("rst_loss", lossDetect, 0);
        check("rst_play", playing, 0);
        check("rst_over", gameOver, 0);
        check("rst_score", score, 0);

        // Inputs outside PLAY have no effect
        groundOut = 1'b1; pipePass = 1'b1; step(); groundOut = 1'b0; pipePass = 1'b0;
        check("idle_loss", lossDetect, 0);
        check("idle_score", score, 0);
        step();

        press_key();
        check("start_play", playing, 1);
        check("start_score", score, 0);
        check("start_loss", lossDetect, 0);

        for (int i = 0; i < 3; i++) pulse_pass();
        check("score3", score, 3);

        // Crash entered 7 edges after start; OVER at the 6th tick edge (start+96)
        groundOut = 1'b1; step(); groundOut = 1'b0;
        check("gnd_loss", lossDetect, 1);
        check("gnd_play", playing, 0);
        wait_over(n);
        check("crash_len", n, 89);
        check("crash_len_range", (n >= 81 && n <= 96), 1);
        check("over_flag", gameOver, 1);
        check("over_loss", lossDetect, 0);
        check("over_score", score, 3);
        pipePass = 1'b1; step(); pipePass = 1'b0;
        check("over_pass_ignored", score, 3);

        press_key();
        check("over_to_idle", gameOver, 0);
        check("idle_play", playing, 0);
        check("idle_score_clr", score, 0);
        step();
        check("idle_waits", playing, 0);
        press_key();
        check("restart_play", playing, 1);

        birdCol = 8'b0001_0000; pipeCol = 8'b1110_0011; step();
        check("gap_no_crash", playing, 1);
        check("gap_no_loss", lossDetect, 0);
        pipeCol = 8'b1111_0000; step();
        check("pipe_crash_loss", lossDetect, 1);
        check("pipe_crash_play", playing, 0);
        birdCol = '0; pipeCol = '0;
        step(); step(); step();
        check("crash_held", lossDetect, 1);

        reset = 1'b1; step();
        check("mid_rst_loss", lossDetect, 0);
        check("mid_rst_play", playing, 0);
        check("mid_rst_over", gameOver, 0);
        check("mid_rst_score", score, 0);
        reset = 1'b0;

        // Frame counter restarts at the press, so OVER lands 85 cycles after the edge-11 crash
        press_key();
        check("post_rst_play", playing, 1);
        for (int i = 0; i < 5; i++) pulse_pass();
        check("score5", score, 5);
        pipePass = 1'b1; groundOut = 1'b1; step(); pipePass = 1'b0; groundOut = 1'b0;
        check("tie_loss", lossDetect, 1);
        check("tie_score", score, 5);
        wait_over(n);
        check("crash_len_after_rst", n, 85);
        check("over_score5", score, 5);

        press_key();
        step();
        press_key();
        check("sat_play", playing, 1);
        for (int i = 0; i < 99; i++) pulse_pass();
        check("score99", score, 99);
        pulse_pass();
        check("score_sat", score, 99);

        reset = 1'b1; step(); reset = 1'b0;
        step();
        KEY0 = 1'b0;
        rises = 0;
        prev = playing;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (playing && !prev) rises++;
            prev = playing;
        end
        KEY0 = 1'b1;
        check("held_key_starts", rises, 1);
        check("held_key_play", playing, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
